mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter MULT_CYC, default 5: busy cycles for multiply-class ops.
REQ-002 Parameter DIV_CYC, default 10: busy cycles for divide-class ops.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low clears all state immediately, independent of clk.
REQ-005 start  in  1  E-stage MDU instruction valid this cycle.
REQ-006 op  in  4  opcode: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU; others are NOP.
REQ-007 src_a, src_b  in  32 each  forwarded rs and rt operands.
REQ-008 req  in  1  CP0 exception/interrupt flush; the E-stage instruction is being cancelled.
REQ-009 busy  out  1  operation in flight; hazard unit stalls MDU instructions while high.
REQ-010 hi, lo  out  32 each  architectural HI/LO registers.
REQ-011 mdu_out  out  32  MFHI/MFLO read result.

Function
REQ-012 FSM states IDLE and RUN; cnt down-counter is 4 bits wide.
REQ-013 Accept condition: start=1, req=0, state=IDLE, op in {1,2,3,4,9,10}; at that edge latch the computed result into pend_hi/pend_lo, set cnt to MULT_CYC (ops 1,2,9,10) or DIV_CYC (ops 3,4), and enter RUN.
REQ-014 busy = (state==RUN); accept at edge t gives busy high for exactly N cycles after t, low afterwards.
REQ-015 In RUN, cnt decrements each edge; at the edge where cnt==1, hi/lo <= pend_hi/pend_lo and state returns to IDLE.
REQ-016 hi/lo never show the new value before busy falls; they change in the same cycle busy falls.
REQ-017 MULT: {hi,lo} = signed 64-bit product; MULTU: unsigned product.
REQ-018 DIV: lo = signed quotient truncated toward zero, hi = remainder with the dividend's sign; DIVU: unsigned quotient and remainder.
REQ-019 0x80000000 DIV 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-020 Divide with src_b==0: full DIV_CYC busy period still runs; hi/lo keep their prior values.
REQ-021 MTHI/MTLO accepted only when start=1, req=0, state=IDLE; hi or lo <= src_a at the next edge, with no busy.
REQ-022 start while RUN is ignored, with no state or HI/LO change; the hazard unit guarantees it does not occur.
REQ-023 req=1 with start=1 blocks acceptance; no state, HI or LO change.
REQ-024 req during RUN does not cancel the operation; it completes and commits normally (the instruction already passed E).
REQ-025 mdu_out is combinational: hi when op=5, lo when op=6, else 0; independent of start and busy.
REQ-026 Undefined op with start=1 is a NOP; busy stays low.

Reset
REQ-027 While reset=0: state=IDLE, cnt=0, hi=0, lo=0, pend_hi=pend_lo=0, busy=0.
REQ-028 Reset assertion mid-RUN aborts the operation; hi/lo read 0 and no commit occurs after release.
REQ-029 First acceptance possible at the first rising edge with reset=1.

Configuration
REQ-030 Macro MDU_SEQ_MADD_EN defined: op 9 MADD commits {hi,lo} + signed product; op 10 MADDU commits {hi,lo} + unsigned product. Accumulation is mod 2^64. Accumulate base is hi/lo sampled at accept. Latency is MULT_CYC.
REQ-031 MDU_SEQ_MADD_EN undefined: ops 9 and 10 are NOPs per REQ-026.

Verification
REQ-032 MULT src_a=0xFFFFFFFE, src_b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> busy 10 cycles, hi/lo unchanged.
REQ-034 MTHI 0x1234 then MFHI -> hi=0x1234 one edge later with busy=0; mdu_out=0x1234 when op=5.
REQ-035 MULTU with start=1 and req=1 -> busy stays 0, hi/lo unchanged; MULTU accepted then req pulsed at cycle 2 -> commit still at cycle 5.
REQ-036 reset driven low at cycle 3 of a DIV -> busy=0 and hi=lo=0 immediately; no later commit.
REQ-037 With MDU_SEQ_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0; without the macro, same stimulus -> busy 0 and hi/lo unchanged.

Source files
------------

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq
// Description : Sequential multiply/divide unit holding the architectural
//               HI/LO registers. Multiply-class ops occupy MULT_CYC cycles and
//               divide-class ops occupy DIV_CYC cycles. The result is computed
//               at accept, parked in pend_hi/pend_lo, and committed to HI/LO on
//               the same edge that busy falls. MTHI/MTLO write in one cycle.
//               Optional feature macro: MDU_SEQ_MADD_EN enables MADD/MADDU
//               (ops 9/10), which accumulate a product into {HI,LO}.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    // Opcode encodings
    localparam logic [3:0] C_OP_MULT  = 4'd1;
    localparam logic [3:0] C_OP_MULTU = 4'd2;
    localparam logic [3:0] C_OP_DIV   = 4'd3;
    localparam logic [3:0] C_OP_DIVU  = 4'd4;
    localparam logic [3:0] C_OP_MFHI  = 4'd5;
    localparam logic [3:0] C_OP_MFLO  = 4'd6;
    localparam logic [3:0] C_OP_MTHI  = 4'd7;
    localparam logic [3:0] C_OP_MTLO  = 4'd8;
    localparam logic [3:0] C_OP_MADD  = 4'd9;
    localparam logic [3:0] C_OP_MADDU = 4'd10;

    // Busy-period lengths loaded into the 4-bit down-counter
    localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYC);
    localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYC);

`ifdef MDU_SEQ_MADD_EN
    localparam logic C_MADD_EN = 1'b1;
`else
    localparam logic C_MADD_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;

    // ------------------------------------------------------------------------
    // Products. The low 64 bits of a product of sign-extended operands equal
    // the signed 64-bit product, so both flavours use an unsigned multiplier.
    // ------------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

    // ------------------------------------------------------------------------
    // Division. Signed divide works on magnitudes and re-applies signs:
    // quotient negative when operand signs differ, remainder follows the
    // dividend. The magnitude of 0x80000000 is 2^31 as an unsigned value, so
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    // A zero divisor is replaced by 1 so the divider never sees zero; the
    // result is discarded in that case anyway.
    // ------------------------------------------------------------------------
    logic        w_b_zero;
    logic [31:0] w_den_u;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den_s;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    assign w_b_zero = (src_b == 32'd0);
    assign w_den_u  = w_b_zero ? 32'd1 : src_b;
    assign w_uq     = src_a / w_den_u;
    assign w_ur     = src_a % w_den_u;

    assign w_a_neg  = src_a[31];
    assign w_b_neg  = src_b[31];
    assign w_a_mag  = w_a_neg ? (~src_a + 32'd1) : src_a;
    assign w_b_mag  = w_b_neg ? (~src_b + 32'd1) : src_b;
    assign w_den_s  = w_b_zero ? 32'd1 : w_b_mag;
    assign w_sq_mag = w_a_mag / w_den_s;
    assign w_sr_mag = w_a_mag % w_den_s;
    assign w_sq     = (w_a_neg ^ w_b_neg) ? (~w_sq_mag + 32'd1) : w_sq_mag;
    assign w_sr     = w_a_neg ? (~w_sr_mag + 32'd1) : w_sr_mag;

    // ------------------------------------------------------------------------
    // Operation decode and result selection
    // ------------------------------------------------------------------------
    logic        w_long_op;
    logic        w_is_div;
    logic [63:0] w_res;
    logic        w_can_issue;
    logic        w_accept;
    logic        w_mthi;
    logic        w_mtlo;

    // Classify the opcode and pick the 64-bit {hi,lo} result to park
    always_comb begin
        w_long_op = 1'b0;
        w_is_div  = 1'b0;
        w_res     = {r_hi, r_lo};
        case (op)
            C_OP_MULT: begin
                w_long_op = 1'b1;
                w_res     = w_prod_s;
            end
            C_OP_MULTU: begin
                w_long_op = 1'b1;
                w_res     = w_prod_u;
            end
            C_OP_DIV: begin
                w_long_op = 1'b1;
                w_is_div  = 1'b1;
                w_res     = w_b_zero ? {r_hi, r_lo} : {w_sr, w_sq};
            end
            C_OP_DIVU: begin
                w_long_op = 1'b1;
                w_is_div  = 1'b1;
                w_res     = w_b_zero ? {r_hi, r_lo} : {w_ur, w_uq};
            end
            C_OP_MADD: begin
                w_long_op = C_MADD_EN;
                w_res     = {r_hi, r_lo} + w_prod_s;
            end
            C_OP_MADDU: begin
                w_long_op = C_MADD_EN;
                w_res     = {r_hi, r_lo} + w_prod_u;
            end
            default: begin
                w_long_op = 1'b0;
            end
        endcase
    end

    // A cancelled (req) or stalled (RUN) instruction never issues
    assign w_can_issue = start && !req && (r_state == S_IDLE);
    assign w_accept    = w_can_issue && w_long_op;
    assign w_mthi      = w_can_issue && (op == C_OP_MTHI);
    assign w_mtlo      = w_can_issue && (op == C_OP_MTLO);

    // ------------------------------------------------------------------------
    // Control FSM, busy counter and HI/LO state
    // ------------------------------------------------------------------------
    // IDLE accepts ops; RUN counts down and commits the parked result at cnt==1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pend_hi <= w_res[63:32];
                        r_pend_lo <= w_res[31:0];
                        r_cnt     <= w_is_div ? C_DIV_CNT : C_MULT_CNT;
                        r_state   <= S_RUN;
                    end else if (w_mthi) begin
                        r_hi <= src_a;
                    end else if (w_mtlo) begin
                        r_lo <= src_a;
                    end
                end
                S_RUN: begin
                    if (r_cnt <= 4'd1) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // MFHI/MFLO read port, driven purely from op
    always_comb begin
        mdu_out = 32'd0;
        if (op == C_OP_MFHI) begin
            mdu_out = r_hi;
        end else if (op == C_OP_MFLO) begin
            mdu_out = r_lo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_seq
// Description : Scoreboard bench for mdu_seq. Stimulus pushes the expected
//               HI/LO and busy length of each long op; a monitor pops and
//               compares when busy falls. Single-cycle effects are checked
//               inline by the stimulus thread.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    always #5 clk = ~clk;

    mdu_seq #(
        .MULT_CYC (5),
        .DIV_CYC  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .req     (req),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mdu_out (mdu_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input string n, input logic [31:0] h, input logic [31:0] l, input int c);
        sb.push_back('{name: n, hi: h, lo: l, cyc: c});
    endtask

    // Present one instruction for exactly one edge, then return 1ns after it
    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic r);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        req   = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;
        req   = 1'b0;
    endtask

    // Bounded wait for busy to drop, then let the monitor see the fall
    task automatic wait_idle(input string n);
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", n, k);
        end
        @(negedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Monitor: measures each busy period, holds HI/LO steady while busy and
    // compares the committed values against the scoreboard head on the fall.
    // ------------------------------------------------------------------------
    logic        m_prev_busy = 1'b0;
    int          m_bcnt      = 0;
    logic [31:0] m_hold_hi   = 32'd0;
    logic [31:0] m_hold_lo   = 32'd0;
    exp_t        m_e;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            m_prev_busy = 1'b0;
            m_bcnt      = 0;
        end else begin
            if (busy) begin
                if (!m_prev_busy) begin
                    m_hold_hi = hi;
                    m_hold_lo = lo;
                    m_bcnt    = 0;
                end
                m_bcnt++;
                chk("hilo_hold_while_busy", {hi, lo}, {m_hold_hi, m_hold_lo});
            end else if (m_prev_busy) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_commit: hi=0x%0h lo=0x%0h with empty scoreboard", hi, lo);
                end else begin
                    m_e = sb.pop_front();
                    chk({m_e.name, "_hi"}, {32'd0, hi}, {32'd0, m_e.hi});
                    chk({m_e.name, "_lo"}, {32'd0, lo}, {32'd0, m_e.lo});
                    chk({m_e.name, "_busy_cycles"}, 64'(m_bcnt), 64'(m_e.cyc));
                end
            end
            m_prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        req   = 1'b0;
        op    = 4'd0;
        src_a = 32'd0;
        src_b = 32'd0;

        // Reset state
        #12;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        op = 4'd5;
        #1;
        chk("reset_mfhi", {32'd0, mdu_out}, 64'd0);
        op = 4'd0;
        @(negedge clk);
        reset = 1'b1;

        // Multiply / divide directed vectors
        push("mult_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        drive(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle("mult_m2x3");

        push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
        drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle("multu_max");

        push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle("div_m7_2");

        push("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        drive(4'd4, 32'd7, 32'd0, 1'b0);
        wait_idle("divu_by0");

        push("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
        drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle("div_ovf");

        push("divu_100_7", 32'd2, 32'd14, 10);
        drive(4'd4, 32'd100, 32'd7, 1'b0);
        wait_idle("divu_100_7");

        push("div_7_m2", 32'd1, 32'hFFFF_FFFD, 10);
        drive(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        wait_idle("div_7_m2");

        // MTHI / MTLO and the MFHI / MFLO read port
        drive(4'd7, 32'h0000_1234, 32'd0, 1'b0);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        op = 4'd5;
        #1;
        chk("mfhi_out", {32'd0, mdu_out}, 64'h1234);
        op = 4'd0;
        drive(4'd8, 32'h0000_ABCD, 32'd0, 1'b0);
        chk("mtlo_lo", {32'd0, lo}, 64'hABCD);
        op = 4'd6;
        #1;
        chk("mflo_out", {32'd0, mdu_out}, 64'hABCD);
        op = 4'd7;
        #1;
        chk("mdu_out_other_op", {32'd0, mdu_out}, 64'd0);
        op = 4'd0;

        // Flush blocks acceptance
        drive(4'd2, 32'd5, 32'd6, 1'b1);
        chk("req_block_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        chk("req_block_busy2", {63'd0, busy}, 64'd0);
        chk("req_block_hilo", {hi, lo}, {32'h1234, 32'hABCD});

        // Flush and a stray start during RUN do not disturb the operation
        push("multu_req_mid", 32'd0, 32'd12, 5);
        drive(4'd2, 32'd3, 32'd4, 1'b0);
        @(posedge clk);
        #1;
        req   = 1'b1;
        start = 1'b1;
        op    = 4'd7;
        src_a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req   = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        wait_idle("multu_req_mid");

        // Undefined opcode is a NOP
        drive(4'd15, 32'd9, 32'd9, 1'b0);
        chk("nop_busy", {63'd0, busy}, 64'd0);
        chk("nop_hilo", {hi, lo}, {32'd0, 32'd12});

        // Multiply-accumulate
        drive(4'd7, 32'd0, 32'd0, 1'b0);
        drive(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_SEQ_MADD_EN
        push("maddu_carry", 32'd1, 32'd0, 5);
        drive(4'd10, 32'd1, 32'd1, 1'b0);
        wait_idle("maddu_carry");
        push("madd_neg", 32'd0, 32'hFFFF_FFFF, 5);
        drive(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_idle("madd_neg");
`else
        drive(4'd10, 32'd1, 32'd1, 1'b0);
        chk("maddu_off_busy", {63'd0, busy}, 64'd0);
        chk("maddu_off_hilo", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
        drive(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("madd_off_busy", {63'd0, busy}, 64'd0);
`endif

        // Reset in the third cycle of a DIV aborts it
        drive(4'd3, 32'd100, 32'd3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("rst_no_commit_busy", {63'd0, busy}, 64'd0);
        chk("rst_no_commit_hilo", {hi, lo}, 64'd0);

        // First acceptance at the first rising edge after reset release
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        op    = 4'd1;
        src_a = 32'd2;
        src_b = 32'd3;
        @(negedge clk);
        reset = 1'b1;
        push("mult_first_edge", 32'd0, 32'd6, 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;
        chk("first_edge_accept", {63'd0, busy}, 64'd1);
        wait_idle("mult_first_edge");

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
